// File: rtl/at_ctrl_pkg.sv
// Shared types and helpers for the AT-command bring-up sequencer.
package at_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        TX_ACK,
        WAIT_TX,
        WAIT_RESP,
        GAP,
        DONE,
        FAULT
    } state_t;

    localparam logic [7:0] LF_BYTE = 8'h0A;

    function automatic int cycles_from_ms(input longint clk, input longint ms);
        return int'((clk * ms) / longint'(1000));
    endfunction

endpackage

// File: rtl/at_timeout_timer.sv
// Saturating down-counter; expired marks the TERM-th enabled cycle after clr
// (TERM=0 behaves as 1) and stays high until the next clr.
module at_timeout_timer #(
    parameter int TERM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TERM < 2) ? 1 : $clog2(TERM + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(TERM);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD_VAL;
        end else if (clr) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt <= W'(1));

endmodule

// File: rtl/at_cmd_sequencer.sv
// Streams LF-terminated AT commands from ROM to the UART transmitter and
// advances, retries or faults on the parser's OK / ERROR / timeout verdict.
//   state     | meaning
//   IDLE      | waiting for start        FETCH  | ROM read latency cycle
//   LOAD      | latch ROM byte           SEND   | wait for idle tx, pulse tx_start
//   TX_ACK    | let tx_busy rise         WAIT_TX| wait end of byte, LF -> response
//   WAIT_RESP | awaiting OK/ERROR/timeout GAP   | idle spacing before next send
//   DONE      | all commands OK          FAULT  | retries exhausted
module at_cmd_sequencer
    import at_ctrl_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int NUM_CMDS    = 7,
    parameter int TIMEOUT_CYC = cycles_from_ms(longint'(CLK_FREQ), longint'(2000)),
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 50_000,
    parameter int ROM_AW      = 8
) (
    input  logic              iCLK,
    input  logic              RST_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              resp_wait,
    input  logic              rx_ok,
    input  logic              rx_error,
    output logic [3:0]        cmd_idx,
    output logic [1:0]        retry_cnt,
    output logic              seq_done,
    output logic              seq_fault
);

    state_t            state, state_nxt;
    logic [ROM_AW-1:0] cmd_base, cmd_base_nxt, rom_addr_nxt;
    logic [7:0]        tx_data_nxt;
    logic              tx_start_nxt, resp_wait_nxt, seq_done_nxt, seq_fault_nxt;
    logic [3:0]        cmd_idx_nxt;
    logic [1:0]        retry_cnt_nxt;
    logic              resp_exp, gap_exp;
    logic              last_cmd, can_retry, resp_ok, resp_fail;

    at_timeout_timer #(.TERM(TIMEOUT_CYC)) u_resp_timer (
        .clk     (iCLK),
        .rst_n   (RST_n),
        .clr     (state != WAIT_RESP),
        .en      (state == WAIT_RESP),
        .expired (resp_exp)
    );

    at_timeout_timer #(.TERM(GAP_CYC)) u_gap_timer (
        .clk     (iCLK),
        .rst_n   (RST_n),
        .clr     (state != GAP),
        .en      (state == GAP),
        .expired (gap_exp)
    );

    // rx_error dominates; an OK arriving on the expiry cycle still wins over the timeout
    assign last_cmd  = (cmd_idx == 4'(NUM_CMDS - 1));
    assign can_retry = (retry_cnt < 2'(MAX_RETRY));
    assign resp_ok   = rx_ok && !rx_error;
    assign resp_fail = rx_error || (resp_exp && !rx_ok);

    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            cmd_base  <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            resp_wait <= 1'b0;
            cmd_idx   <= '0;
            retry_cnt <= '0;
            seq_done  <= 1'b0;
            seq_fault <= 1'b0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= rom_addr_nxt;
            cmd_base  <= cmd_base_nxt;
            tx_data   <= tx_data_nxt;
            tx_start  <= tx_start_nxt;
            resp_wait <= resp_wait_nxt;
            cmd_idx   <= cmd_idx_nxt;
            retry_cnt <= retry_cnt_nxt;
            seq_done  <= seq_done_nxt;
            seq_fault <= seq_fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, FAULT: if (start) state_nxt = FETCH;
            FETCH:             state_nxt = LOAD;
            LOAD:              state_nxt = SEND;
            SEND:              if (!tx_busy) state_nxt = TX_ACK;
            TX_ACK:            state_nxt = WAIT_TX;
            WAIT_TX:           if (!tx_busy) state_nxt = (tx_data == LF_BYTE) ? WAIT_RESP : FETCH;
            WAIT_RESP: begin
                if (resp_ok)        state_nxt = last_cmd ? DONE : GAP;
                else if (resp_fail) state_nxt = can_retry ? GAP : FAULT;
            end
            GAP:               if (gap_exp) state_nxt = FETCH;
            default:           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rom_addr_nxt  = rom_addr;
        cmd_base_nxt  = cmd_base;
        tx_data_nxt   = tx_data;
        tx_start_nxt  = 1'b0;
        resp_wait_nxt = resp_wait;
        cmd_idx_nxt   = cmd_idx;
        retry_cnt_nxt = retry_cnt;
        seq_done_nxt  = seq_done;
        seq_fault_nxt = seq_fault;
        case (state)
            IDLE, DONE, FAULT: begin
                if (start) begin
                    rom_addr_nxt  = '0;
                    cmd_base_nxt  = '0;
                    cmd_idx_nxt   = '0;
                    retry_cnt_nxt = '0;
                    seq_done_nxt  = 1'b0;
                    seq_fault_nxt = 1'b0;
                end
            end
            LOAD: tx_data_nxt = rom_data;
            SEND: if (!tx_busy) tx_start_nxt = 1'b1;
            WAIT_TX: begin
                if (!tx_busy) begin
                    if (tx_data == LF_BYTE) resp_wait_nxt = 1'b1;
                    else                    rom_addr_nxt  = rom_addr + ROM_AW'(1);
                end
            end
            WAIT_RESP: begin
                if (resp_ok) begin
                    resp_wait_nxt = 1'b0;
                    if (last_cmd) begin
                        seq_done_nxt = 1'b1;
                    end else begin
                        retry_cnt_nxt = '0;
                        cmd_idx_nxt   = cmd_idx + 4'd1;
                        cmd_base_nxt  = rom_addr + ROM_AW'(1);
                        rom_addr_nxt  = rom_addr + ROM_AW'(1);
                    end
                end else if (resp_fail) begin
                    resp_wait_nxt = 1'b0;
                    if (can_retry) begin
                        retry_cnt_nxt = retry_cnt + 2'd1;
                        rom_addr_nxt  = cmd_base;
                    end else begin
                        seq_fault_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
